output_drain: RTL and testbench
===============================

OUTPUT_DRAIN -- requirements
Module: output_drain

Interface
REQ-001 SHALL have parameter IO_DATA_WIDTH, default 16: width of one output value.
REQ-002 SHALL have parameter NB_LANES, default 16: values per parallel result block (one per MAC lane).
REQ-003 SHALL have parameters FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS, each default 1024, 1024, 64: coordinate ranges.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port arst_n_in, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port load_valid, input, 1 bit: a result block is offered.
REQ-007 SHALL have port load_ready, output, 1 bit: block can be accepted.
REQ-008 SHALL have port load_data, input, NB_LANES*IO_DATA_WIDTH bits: lane i at bits [i*IO_DATA_WIDTH +: IO_DATA_WIDTH], signed.
REQ-009 SHALL have ports load_x, load_y, load_ch_base, inputs, clog2 of FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS bits: block coordinates.
REQ-010 SHALL have port out, output, IO_DATA_WIDTH bits signed: serialized value.
REQ-011 SHALL have port output_valid, output, 1 bit; port output_ready, input, 1 bit: downstream handshake.
REQ-012 SHALL have ports output_x, output_y, output_ch, outputs, same widths as load coordinates.
REQ-013 SHALL have port busy, output, 1 bit: any block buffered or draining.

Function
REQ-014 SHALL transfer a block only on a clk edge with load_valid and load_ready both high.
REQ-015 SHALL transfer a beat only on a clk edge with output_valid and output_ready both high.
REQ-016 SHALL hold a two-entry block buffer (ping-pong); load_ready SHALL be high iff fewer than 2 entries are occupied, driven from registers only.
REQ-017 SHALL drain the oldest entry lanes 0..NB_LANES-1 in order, one beat per accepted handshake; output_ch = load_ch_base + lane, output_x/y = block values.
REQ-018 SHALL use FSM states IDLE (no entry, output_valid low) and DRAIN (output_valid high); IDLE->DRAIN on entry present; DRAIN->IDLE after last beat if no further entry, else stay in DRAIN with lane 0 of next entry.
REQ-019 SHALL present the first beat of a block loaded into an empty buffer on the cycle after acceptance (1-cycle latency).
REQ-020 SHALL keep out, output_x, output_y, output_ch, output_valid stable while output_valid high and output_ready low.
REQ-021 SHALL deliver back-to-back blocks with no idle beat between last lane of one and lane 0 of next when output_ready stays high.
REQ-022 SHALL accept a load on the same edge as the last beat of the draining entry; occupancy then stays unchanged.
REQ-023 SHALL compute output_ch modulo 2^clog2(OUTPUT_NB_CHANNELS) (natural wrap); load_ch_base not a multiple of NB_LANES is legal and wraps identically.
REQ-024 SHALL keep busy high iff occupancy nonzero.
REQ-025 SHALL ignore load_data/coordinates when no load handshake occurs.

Reset
REQ-026 SHALL on arst_n_in low immediately force: state IDLE, occupancy 0, lane counter 0, output_valid 0, load_ready 0 while asserted then 1 after deassertion edge, busy 0, out/output_x/output_y/output_ch 0.
REQ-027 SHALL discard any buffered or partially drained block on reset mid-operation; no beat of it appears afterwards.

Structure
REQ-028 SHALL take IO_DATA_WIDTH/NB_LANES defaults and the state enum type from the shared accelerator package.
REQ-029 SHALL implement the two-entry buffer as sub-module drain_buf (write port, read port with lane select, occupancy flags).

Verification
REQ-030 Single block, lanes = 100+i, x=3,y=5,ch_base=16, output_ready=1 -> 16 beats next cycle onward, out=100..115, ch=16..31, then output_valid=0, busy=0.
REQ-031 Two blocks offered back-to-back, output_ready=1 -> 32 contiguous beats, third load_valid sees load_ready=0 until first block's last beat.
REQ-032 output_ready toggled 1,0,0,1 pattern -> each value appears exactly once, outputs stable across stalls, order preserved.
REQ-033 ch_base=56, OUTPUT_NB_CHANNELS=64 -> output_ch 56..63 then 0..7.
REQ-034 arst_n_in pulsed low at lane 7 of a full buffer -> all outputs 0 same cycle, no stale beats after release, new block drains correctly.
REQ-035 Load accepted on same edge as last beat with buffer full -> no lost or duplicated block, load_ready rule holds.

Source files
------------

// File: rtl/output_drain_pkg.sv
// Shared accelerator definitions: default datapath geometry and the drain FSM state type.
`default_nettype none

package output_drain_pkg;

  localparam int DEF_IO_DATA_WIDTH = 16;
  localparam int DEF_NB_LANES      = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage

`default_nettype wire

// File: rtl/output_drain_buf.sv
// Two-entry ping-pong block buffer with lane-selectable read port and occupancy tracking.
`default_nettype none

module drain_buf
  import output_drain_pkg::*;
#(
  parameter int IO_DATA_WIDTH = DEF_IO_DATA_WIDTH,
  parameter int NB_LANES      = DEF_NB_LANES,
  parameter int X_W           = 10,
  parameter int Y_W           = 10,
  parameter int CH_W          = 6,
  parameter int LANE_W        = $clog2(NB_LANES)
) (
  input  logic                              clk,
  input  logic                              arst_n_in,
  input  logic                              wr_en,
  input  logic [NB_LANES*IO_DATA_WIDTH-1:0] wr_data,
  input  logic [X_W-1:0]                    wr_x,
  input  logic [Y_W-1:0]                    wr_y,
  input  logic [CH_W-1:0]                   wr_ch_base,
  input  logic                              rd_pop,
  input  logic [LANE_W-1:0]                 rd_lane,
  output logic [IO_DATA_WIDTH-1:0]          rd_value,
  output logic [X_W-1:0]                    rd_x,
  output logic [Y_W-1:0]                    rd_y,
  output logic [CH_W-1:0]                   rd_ch_base,
  output logic [1:0]                        count,
  output logic [1:0]                        count_next
);

  logic [NB_LANES*IO_DATA_WIDTH-1:0] mem_data [2];
  logic [X_W-1:0]                    mem_x    [2];
  logic [Y_W-1:0]                    mem_y    [2];
  logic [CH_W-1:0]                   mem_ch   [2];
  logic                              wr_ptr;
  logic                              rd_ptr;

  // Payload storage needs no reset: nothing is read out unless occupancy says it is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= wr_data;
      mem_x[wr_ptr]    <= wr_x;
      mem_y[wr_ptr]    <= wr_y;
      mem_ch[wr_ptr]   <= wr_ch_base;
    end
  end

  always_comb begin
    count_next = count;
    case ({wr_en, rd_pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en)  wr_ptr <= ~wr_ptr;
      if (rd_pop) rd_ptr <= ~rd_ptr;
      count <= count_next;
    end
  end

  assign rd_value   = mem_data[rd_ptr][rd_lane*IO_DATA_WIDTH +: IO_DATA_WIDTH];
  assign rd_x       = mem_x[rd_ptr];
  assign rd_y       = mem_y[rd_ptr];
  assign rd_ch_base = mem_ch[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/output_drain.sv
// Serializes parallel MAC result blocks into one value per handshake with per-value coordinates.
`default_nettype none

module output_drain
  import output_drain_pkg::*;
#(
  parameter int IO_DATA_WIDTH      = DEF_IO_DATA_WIDTH,
  parameter int NB_LANES           = DEF_NB_LANES,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64
) (
  input  logic                                    clk,
  input  logic                                    arst_n_in,
  input  logic                                    load_valid,
  output logic                                    load_ready,
  input  logic [NB_LANES*IO_DATA_WIDTH-1:0]       load_data,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    load_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   load_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   load_ch_base,
  output logic signed [IO_DATA_WIDTH-1:0]         out,
  output logic                                    output_valid,
  input  logic                                    output_ready,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    output_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   output_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   output_ch,
  output logic                                    busy
);

  localparam int X_W    = $clog2(FEATURE_MAP_WIDTH);
  localparam int Y_W    = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CH_W   = $clog2(OUTPUT_NB_CHANNELS);
  localparam int LANE_W = $clog2(NB_LANES);

  drain_state_e              state;
  drain_state_e              state_next;
  logic [LANE_W-1:0]         lane;
  logic                      ready_reg;
  logic [1:0]                count;
  logic [1:0]                count_next;
  logic                      load_fire;
  logic                      beat_fire;
  logic                      last_lane;
  logic                      pop;
  logic [IO_DATA_WIDTH-1:0]  rd_value;
  logic [X_W-1:0]            rd_x;
  logic [Y_W-1:0]            rd_y;
  logic [CH_W-1:0]           rd_ch_base;

  assign load_fire = load_valid & ready_reg;
  assign beat_fire = output_valid & output_ready;
  assign last_lane = (lane == LANE_W'(NB_LANES - 1));
  assign pop       = beat_fire & last_lane;

  drain_buf #(
    .IO_DATA_WIDTH (IO_DATA_WIDTH),
    .NB_LANES      (NB_LANES),
    .X_W           (X_W),
    .Y_W           (Y_W),
    .CH_W          (CH_W),
    .LANE_W        (LANE_W)
  ) u_buf (
    .clk        (clk),
    .arst_n_in  (arst_n_in),
    .wr_en      (load_fire),
    .wr_data    (load_data),
    .wr_x       (load_x),
    .wr_y       (load_y),
    .wr_ch_base (load_ch_base),
    .rd_pop     (pop),
    .rd_lane    (lane),
    .rd_value   (rd_value),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_ch_base (rd_ch_base),
    .count      (count),
    .count_next (count_next)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count_next != 2'd0) state_next = DRAIN;
      DRAIN:   if (pop && count_next == 2'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ready_reg resets low so load_ready stays low for the whole reset pulse.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state     <= IDLE;
      lane      <= '0;
      ready_reg <= 1'b0;
    end else begin
      state     <= state_next;
      ready_reg <= (count_next != 2'd2);
      if (beat_fire) lane <= last_lane ? '0 : lane + 1'b1;
    end
  end

  assign output_valid = (state == DRAIN);
  assign load_ready   = ready_reg;
  assign busy         = (count != 2'd0);

  // Gating keeps the outputs at zero whenever no beat is presented, including during reset.
  assign out       = output_valid ? rd_value : '0;
  assign output_x  = output_valid ? rd_x : '0;
  assign output_y  = output_valid ? rd_y : '0;
  assign output_ch = output_valid ? (rd_ch_base + CH_W'(lane)) : '0;

endmodule

`default_nettype wire

// File: tb/tb_output_drain.sv
// Directed self-checking bench for output_drain using immediate assertions.
`default_nettype none

module tb_output_drain;

  localparam int W  = 16;
  localparam int L  = 16;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int CW = 6;

  logic              clk = 1'b0;
  logic              arst_n_in = 1'b0;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [L*W-1:0]    load_data = '0;
  logic [XW-1:0]     load_x = '0;
  logic [YW-1:0]     load_y = '0;
  logic [CW-1:0]     load_ch_base = '0;
  logic signed [W-1:0] out;
  logic              output_valid;
  logic              output_ready = 1'b0;
  logic [XW-1:0]     output_x;
  logic [YW-1:0]     output_y;
  logic [CW-1:0]     output_ch;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  output_drain #(
    .IO_DATA_WIDTH      (W),
    .NB_LANES           (L),
    .FEATURE_MAP_WIDTH  (1024),
    .FEATURE_MAP_HEIGHT (1024),
    .OUTPUT_NB_CHANNELS (64)
  ) dut (
    .clk          (clk),
    .arst_n_in    (arst_n_in),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_x       (load_x),
    .load_y       (load_y),
    .load_ch_base (load_ch_base),
    .out          (out),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_x     (output_x),
    .output_y     (output_y),
    .output_ch    (output_ch),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed {valid, out, x, y, ch} as expected for one presented beat.
  function automatic logic [63:0] beat(input int v, input int x, input int y, input int c);
    return {21'd0, 1'b1, W'(v), XW'(x), YW'(y), CW'(c)};
  endfunction

  function automatic logic [63:0] obs_beat();
    return {21'd0, output_valid, out, output_x, output_y, output_ch};
  endfunction

  function automatic logic [L*W-1:0] make_data(input int base);
    logic [L*W-1:0] d;
    d = '0;
    for (int i = 0; i < L; i++) d[i*W +: W] = W'(base + i);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input int base, input int x, input int y, input int chb);
    load_data    = make_data(base);
    load_x       = XW'(x);
    load_y       = YW'(y);
    load_ch_base = CW'(chb);
  endtask

  task automatic load_blk(input int base, input int x, input int y, input int chb);
    load_valid = 1'b1;
    set_load(base, x, y, chb);
    chk("load_ready_pre", {63'd0, load_ready}, 64'd1);
    tick();
    load_valid = 1'b0;
  endtask

  // Drains lanes first..L-1 of the current block; optional 1,0,0,1 output_ready pattern.
  task automatic drain_block(input string tag, input int base, input int x, input int y,
                             input int chb, input int first, input bit stall);
    int lane;
    int step;
    lane = first;
    step = 0;
    while (lane < L && step < 100) begin
      output_ready = stall ? ((step % 4 == 0) || (step % 4 == 3)) : 1'b1;
      if (!load_valid) begin
        load_data    = {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
        load_x       = XW'($urandom);
        load_y       = YW'($urandom);
        load_ch_base = CW'($urandom);
      end
      chk(tag, obs_beat(), beat(base + lane, x, y, chb + lane));
      tick();
      if (output_ready) lane++;
      step++;
    end
    chk({tag, "_lanes_done"}, 64'(lane), 64'(L));
    output_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk("reset_outs", obs_beat(), 64'd0);
    chk("reset_ready_busy", {62'd0, load_ready, busy}, 64'd0);
    @(negedge clk);
    arst_n_in = 1'b1;
    tick();
    chk("ready_after_rst", {62'd0, load_ready, busy}, 64'b10);

    // Single block, 1-cycle latency, 16 contiguous beats
    output_ready = 1'b1;
    load_blk(100, 3, 5, 16);
    chk("single_busy", {63'd0, busy}, 64'd1);
    drain_block("single", 100, 3, 5, 16, 0, 1'b0);
    chk("single_idle", {62'd0, output_valid, busy}, 64'd0);

    // Back-to-back blocks with a third load held off while full
    output_ready = 1'b1;
    load_valid   = 1'b1;
    set_load(200, 1, 2, 0);
    tick();
    chk("b2b_a", obs_beat(), beat(200, 1, 2, 0));
    set_load(300, 7, 9, 16);
    chk("b2b_ready_b", {63'd0, load_ready}, 64'd1);
    tick();
    set_load(400, 4, 4, 32);
    for (int i = 1; i < L; i++) begin
      chk("b2b_a", obs_beat(), beat(200 + i, 1, 2, i));
      chk("full_ready_low", {63'd0, load_ready}, 64'd0);
      tick();
    end
    chk("b2b_b", obs_beat(), beat(300, 7, 9, 16));
    chk("ready_after_last", {63'd0, load_ready}, 64'd1);
    tick();
    load_valid = 1'b0;
    drain_block("b2b_b", 300, 7, 9, 16, 1, 1'b0);
    drain_block("b2b_c", 400, 4, 4, 32, 0, 1'b0);
    chk("b2b_idle", {62'd0, output_valid, busy}, 64'd0);

    // Stall pattern with signed values
    load_blk(-5, 20, 30, 40);
    drain_block("stall", -5, 20, 30, 40, 0, 1'b1);
    chk("stall_idle", {62'd0, output_valid, busy}, 64'd0);

    // Channel wrap plus load on the same edge as the last beat
    output_ready = 1'b1;
    load_blk(500, 6, 8, 56);
    for (int i = 0; i < L - 1; i++) begin
      chk("wrap", obs_beat(), beat(500 + i, 6, 8, 56 + i));
      tick();
    end
    chk("wrap_last", obs_beat(), beat(515, 6, 8, 7));
    load_valid = 1'b1;
    set_load(600, 2, 3, 8);
    chk("same_edge_ready", {63'd0, load_ready}, 64'd1);
    tick();
    load_valid = 1'b0;
    chk("same_edge_occ", {62'd0, busy, load_ready}, 64'b11);
    drain_block("wrap_next", 600, 2, 3, 8, 0, 1'b0);
    chk("wrap_idle", {62'd0, output_valid, busy}, 64'd0);

    // Reset in the middle of a full buffer
    load_valid = 1'b1;
    set_load(700, 1, 1, 0);
    tick();
    set_load(800, 2, 2, 16);
    tick();
    load_valid = 1'b0;
    repeat (6) tick();
    chk("pre_rst_lane7", obs_beat(), beat(707, 1, 1, 7));
    arst_n_in = 1'b0;
    #1;
    chk("mid_rst_outs", obs_beat(), 64'd0);
    chk("mid_rst_ready_busy", {62'd0, load_ready, busy}, 64'd0);
    tick();
    chk("mid_rst_hold", {61'd0, output_valid, load_ready, busy}, 64'd0);
    @(negedge clk);
    arst_n_in = 1'b1;
    tick();
    chk("post_rst_ready", {63'd0, load_ready}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("no_stale", {62'd0, output_valid, busy}, 64'd0);
      tick();
    end
    load_blk(900, 11, 13, 0);
    drain_block("post_rst", 900, 11, 13, 0, 0, 1'b0);
    chk("final_idle", {62'd0, output_valid, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
